parity_generator: RTL and testbench

PARITY_GENERATOR -- requirements
Module: parity_generator

---
 rtl/parity_generator.sv | 134 +++++++++++++
 tb/tb_parity_generator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/parity_generator.sv
// Registered parity generator. It captures a data word when data_valid is high
// and produces even/odd parity, a popcount and a copy of the word one clock later.
// The word is cut into fixed-width lanes. Each lane reduces its own slice, and
// the lane results are combined before the output registers.

// Per-lane reduction: ones count and XOR parity of one slice
module parity_lane #(
    parameter int LANE_W = 8,
    parameter int CW     = $clog2(LANE_W + 1)
) (
    input  logic [LANE_W-1:0] bits,
    output logic [CW-1:0]     cnt,
    output logic              par
);

    // Popcount and parity of the slice. Both come from the same bits, so
    // cnt[0] == par by construction.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < LANE_W; i++) begin
            cnt = cnt + CW'(bits[i]);
        end
        par = ^bits;
    end

endmodule

module parity_generator #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,        // active-high synchronous reset
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  even_parity,
    output logic                  odd_parity,
    output logic                  parity_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]      ones_count
);

    localparam int LANE_W    = (DATA_WIDTH < 8) ? DATA_WIDTH : 8;
    localparam int NUM_LANES = (DATA_WIDTH + LANE_W - 1) / LANE_W;
    localparam int PAD_W     = NUM_LANES * LANE_W;
    localparam int LCW       = $clog2(LANE_W + 1);
    // The accumulator is wide enough for the padded word. This makes the
    // per-lane counts fit even when DATA_WIDTH is tiny.
    localparam int SUM_W     = $clog2(PAD_W + 1);
    localparam int STAGES    = 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CNT_W-1:0]      cnt;
        logic                  even;
    } result_t;

    logic [PAD_W-1:0]                data_pad;
    logic [NUM_LANES-1:0][LANE_W-1:0] lane_bits;
    logic [NUM_LANES-1:0][LCW-1:0]    lane_cnt;
    logic [NUM_LANES-1:0]             lane_par;
    logic [SUM_W-1:0]                 cnt_sum;
    logic                             par_sum;
    result_t                          res_d;
    result_t                          res_q;
    logic                             odd_q;
    logic [STAGES:0]                  vld_pipe;

    // Zero-pad the word up to a whole number of lanes. Zeros change neither
    // the count nor the parity.
    always_comb begin
        data_pad                 = '0;
        data_pad[DATA_WIDTH-1:0] = data_in;
        lane_bits                = data_pad;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            parity_lane #(
                .LANE_W (LANE_W),
                .CW     (LCW)
            ) u_lane (
                .bits (lane_bits[g]),
                .cnt  (lane_cnt[g]),
                .par  (lane_par[g])
            );
        end
    endgenerate

    // Combine the lane results into the next-state result word
    always_comb begin
        cnt_sum = '0;
        par_sum = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt_sum = cnt_sum + SUM_W'(lane_cnt[i]);
            par_sum = par_sum ^ lane_par[i];
        end
        res_d.data = data_in;
        res_d.cnt  = CNT_W'(cnt_sum);
        res_d.even = par_sum;
    end

    assign vld_pipe[0] = data_valid;

    // Result registers. Reset wins over data_valid. When no word is accepted,
    // the last result is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            res_q <= '0;
            odd_q <= 1'b1;
        end else if (data_valid) begin
            res_q <= res_d;
            odd_q <= ~res_d.even;
        end
    end

    // Valid shift register. It produces a one-cycle pulse for each accepted word.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // odd_parity has its own flop, so every output comes straight from a register.
    assign even_parity  = res_q.even;
    assign odd_parity   = odd_q;
    assign ones_count   = res_q.cnt;
    assign data_out     = res_q.data;
    assign parity_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_parity_generator.sv
// Directed table-driven bench for parity_generator (8-bit), plus a short
// 12-bit sequence that exercises the multi-lane combine.
module tb_parity_generator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        even_parity, odd_parity, parity_valid;
    logic [7:0]  data_out;
    logic [3:0]  ones_count;

    logic [11:0] w_in;
    logic        w_valid;
    logic        w_even, w_odd, w_pv;
    logic [11:0] w_out;
    logic [3:0]  w_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    parity_generator #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .even_parity  (even_parity),
        .odd_parity   (odd_parity),
        .parity_valid (parity_valid),
        .data_out     (data_out),
        .ones_count   (ones_count)
    );

    parity_generator #(.DATA_WIDTH(12)) dut_w (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (w_in),
        .data_valid   (w_valid),
        .even_parity  (w_even),
        .odd_parity   (w_odd),
        .parity_valid (w_pv),
        .data_out     (w_out),
        .ones_count   (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic       e_even;
        logic       e_odd;
        logic       e_pv;
        logic [3:0] e_cnt;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic e, input logic o, input logic p,
                       input logic [3:0] c, input logic [7:0] q);
        vec_t t;
        t.rst = r; t.vld = v; t.din = d;
        t.e_even = e; t.e_odd = o; t.e_pv = p; t.e_cnt = c; t.e_data = q;
        vecs.push_back(t);
    endtask

    // Drive on the falling edge, let one rising edge pass, then sample 1ns later.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst_n = r; data_valid = v; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_w(input logic r, input logic v, input logic [11:0] d);
        @(negedge clk);
        rst_n = r; w_valid = v; w_in = d;
        data_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; data_valid = 1'b0; data_in = '0;
        w_valid = 1'b0; w_in = '0;

        //   rst  vld  din     even odd pv cnt data
        add(1, 0, 8'h00,   0, 1, 0, 0, 8'h00);  // reset cycle 1
        add(1, 0, 8'h00,   0, 1, 0, 0, 8'h00);  // reset cycle 2
        add(0, 1, 8'hAA,   0, 1, 1, 4, 8'hAA);
        add(0, 0, 8'h55,   0, 1, 0, 4, 8'hAA);  // hold, pulse drops
        add(0, 0, 8'h00,   0, 1, 0, 4, 8'hAA);
        add(0, 1, 8'hAB,   1, 0, 1, 5, 8'hAB);
        add(0, 1, 8'h00,   0, 1, 1, 0, 8'h00);
        add(0, 1, 8'hFF,   0, 1, 1, 8, 8'hFF);
        add(0, 0, 8'h01,   0, 1, 0, 8, 8'hFF);  // idle data change
        add(0, 0, 8'h03,   0, 1, 0, 8, 8'hFF);
        add(0, 1, 8'h01,   1, 0, 1, 1, 8'h01);  // back-to-back
        add(0, 1, 8'h03,   0, 1, 1, 2, 8'h03);
        add(1, 1, 8'h01,   0, 1, 0, 0, 8'h00);  // reset beats valid
        add(0, 1, 8'h80,   1, 0, 1, 1, 8'h80);
        add(1, 0, 8'hFF,   0, 1, 0, 0, 8'h00);
        add(0, 1, 8'h07,   1, 0, 1, 3, 8'h07);
        add(0, 0, 8'hFE,   1, 0, 0, 3, 8'h07);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].din);
            chk($sformatf("v%0d even", i), 32'(even_parity),  32'(vecs[i].e_even));
            chk($sformatf("v%0d odd",  i), 32'(odd_parity),   32'(vecs[i].e_odd));
            chk($sformatf("v%0d pv",   i), 32'(parity_valid), 32'(vecs[i].e_pv));
            chk($sformatf("v%0d cnt",  i), 32'(ones_count),   32'(vecs[i].e_cnt));
            chk($sformatf("v%0d data", i), 32'(data_out),     32'(vecs[i].e_data));
            chk($sformatf("v%0d inv_ne", i), 32'(even_parity ^ odd_parity), 32'd1);
            chk($sformatf("v%0d inv_c0", i), 32'(ones_count[0]), 32'(vecs[i].e_even));
        end

        // Mid-stream reset held over a valid burst, then a clean restart.
        step(0, 1, 8'h3C);
        chk("burst even", 32'(even_parity), 32'd0);
        chk("burst cnt",  32'(ones_count),  32'd4);
        step(1, 1, 8'h01);
        step(1, 1, 8'h7F);
        chk("rst hold pv",  32'(parity_valid), 32'd0);
        chk("rst hold odd", 32'(odd_parity),   32'd1);
        chk("rst hold cnt", 32'(ones_count),   32'd0);
        step(0, 1, 8'hFE);
        chk("post rst even", 32'(even_parity), 32'd1);
        chk("post rst cnt",  32'(ones_count),  32'd7);
        chk("post rst pv",   32'(parity_valid), 32'd1);
        step(0, 0, 8'h00);
        chk("post rst drop", 32'(parity_valid), 32'd0);

        // 12-bit instance: two lanes, with a partial second lane.
        step_w(0, 1, 12'hFFF);
        chk("w fff cnt",  32'(w_cnt),  32'd12);
        chk("w fff even", 32'(w_even), 32'd0);
        chk("w fff odd",  32'(w_odd),  32'd1);
        step_w(0, 1, 12'h801);
        chk("w 801 cnt",  32'(w_cnt),  32'd2);
        chk("w 801 data", 32'(w_out),  32'h801);
        step_w(0, 1, 12'hB00);
        chk("w b00 cnt",  32'(w_cnt),  32'd3);
        chk("w b00 even", 32'(w_even), 32'd1);
        chk("w b00 pv",   32'(w_pv),   32'd1);
        step_w(0, 0, 12'h000);
        chk("w hold cnt", 32'(w_cnt),  32'd3);
        chk("w hold pv",  32'(w_pv),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
